// File: rtl/wr_pack_ctrl.sv
// User-side write controller: packs user words into AXI beats, groups beats into bursts and
// issues one ring-addressed request per burst. Optional status outputs under WR_PACK_STATUS_EN.
module wr_pack_ctrl #(
  parameter int unsigned USER_DATA_WIDTH = 16,
  parameter int unsigned AXI_ADDR_WIDTH  = 32,
  parameter int unsigned AXI_DATA_WIDTH  = 128,
  parameter int unsigned BURST_BYTES     = 4096
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          ddr_init_done,
  input  logic [AXI_ADDR_WIDTH-1:0]     user_base_addr,
  input  logic [AXI_ADDR_WIDTH-1:0]     user_end_addr,
  input  logic                          user_wr_en,
  input  logic [USER_DATA_WIDTH-1:0]    user_wr_data,
  input  logic                          user_wr_last,
  output logic                          user_wr_ready,
  output logic [AXI_DATA_WIDTH-1:0]     wr_data_out,
  output logic [AXI_DATA_WIDTH/8-1:0]   wr_data_strb,
  output logic                          wr_data_valid,
  output logic                          wr_data_last,
  input  logic                          wr_data_ready,
  output logic                          wr_req_en,
  output logic [AXI_ADDR_WIDTH-1:0]     wr_addr_out,
  output logic [7:0]                    wr_burst_len,
`ifdef WR_PACK_STATUS_EN
  output logic [31:0]                   wr_burst_total,
  output logic                          wr_busy,
`endif
  input  logic                          wr_req_ack
);

  localparam int unsigned RATIO = AXI_DATA_WIDTH / USER_DATA_WIDTH;
  localparam int unsigned UB    = USER_DATA_WIDTH / 8;
  localparam int unsigned AB    = AXI_DATA_WIDTH / 8;
  localparam int unsigned BEATS = BURST_BYTES / AB;
  localparam int unsigned PCW   = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned AW    = AXI_ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_REQ} state_t;

  state_t                    r_state, w_state_nxt;
  logic [2:0]                r_init_sync;
  logic [AXI_DATA_WIDTH-1:0] r_pack_buf, r_data, w_beat;
  logic [PCW-1:0]            r_pack_cnt;
  logic [AB-1:0]             r_strb, w_strb;
  logic                      r_valid, r_last;
  logic [7:0]                r_beat_cnt, r_len, r_pend_len, w_beat_idx;
  logic                      r_pend;
  logic [AW-1:0]             r_addr, w_addr_cur, w_addr_next;
  logic                      r_addr_set;
  logic                      w_hs, w_last_hs, w_acc, w_full, w_flush, w_burst_end, w_ack, w_wrap;
  logic                      w_user_ready;

  assign w_hs         = r_valid & wr_data_ready;
  assign w_last_hs    = w_hs & r_last;
  assign w_user_ready = (r_state == S_FILL) & ~(r_valid & ~wr_data_ready);
  assign w_acc        = user_wr_en & w_user_ready;
  assign w_full       = (r_pack_cnt == PCW'(RATIO - 1));
  assign w_flush      = w_acc & (w_full | user_wr_last);
  assign w_beat_idx   = w_last_hs ? '0 : r_beat_cnt + 8'(w_hs);
  assign w_burst_end  = (w_beat_idx == 8'(BEATS - 1));
  assign w_ack        = (r_state == S_REQ) & wr_req_ack;

  // The reset address follows the quasi-static base input until the first ack has
  // advanced the ring, avoiding an asynchronous load of a non-constant value.
  assign w_addr_cur  = r_addr_set ? r_addr : user_base_addr;
  assign w_addr_next = w_addr_cur + (AW'(r_len) + AW'(1)) * AW'(AB);
  assign w_wrap      = (w_addr_next + AW'(BURST_BYTES)) > user_end_addr;

  always_comb begin
    w_beat = r_pack_buf;
    w_beat[32'(r_pack_cnt) * USER_DATA_WIDTH +: USER_DATA_WIDTH] = user_wr_data;
    w_strb = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (i <= 32'(r_pack_cnt)) w_strb[i*UB +: UB] = '1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_init_sync[2]) w_state_nxt = S_FILL;
      S_FILL:  if (w_last_hs) w_state_nxt = S_REQ;
      S_REQ:   if (w_ack) w_state_nxt = (r_pend | w_last_hs) ? S_REQ : S_FILL;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_init_sync <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_sync <= {r_init_sync[1:0], ddr_init_done};
    end
  end

  // Beat counter clears on the last-beat handshake so a beat formed in that same cycle
  // (or handshaken while a request is outstanding) is counted toward the next burst.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pack_buf <= '0;
      r_pack_cnt <= '0;
      r_data     <= '0;
      r_strb     <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      if (w_hs) r_beat_cnt <= r_last ? '0 : r_beat_cnt + 8'd1;
      if (w_flush) begin
        r_data     <= w_beat;
        r_strb     <= w_strb;
        r_last     <= w_burst_end | user_wr_last;
        r_valid    <= 1'b1;
        r_pack_buf <= '0;
        r_pack_cnt <= '0;
      end else begin
        if (w_hs) r_valid <= 1'b0;
        if (w_acc) begin
          r_pack_buf <= w_beat;
          r_pack_cnt <= r_pack_cnt + PCW'(1);
        end
      end
    end
  end

  // A last beat handshaken while a request is outstanding is queued as a pending burst.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_len      <= '0;
      r_pend     <= 1'b0;
      r_pend_len <= '0;
      r_addr     <= '0;
      r_addr_set <= 1'b0;
    end else if (r_state == S_FILL) begin
      if (w_last_hs) r_len <= r_beat_cnt;
    end else if (r_state == S_REQ) begin
      if (w_ack) begin
        r_addr     <= w_wrap ? user_base_addr : w_addr_next;
        r_addr_set <= 1'b1;
        if (r_pend) begin
          r_len  <= r_pend_len;
          r_pend <= 1'b0;
        end else if (w_last_hs) begin
          r_len <= r_beat_cnt;
        end
      end else if (w_last_hs) begin
        r_pend     <= 1'b1;
        r_pend_len <= r_beat_cnt;
      end
    end
  end

`ifdef WR_PACK_STATUS_EN
  logic [31:0] r_total;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    r_total <= '0;
    else if (w_ack) r_total <= r_total + 32'd1;
  end
  assign wr_burst_total = r_total;
  assign wr_busy        = (r_state != S_FILL) | r_valid | (r_pack_cnt != '0);
`endif

  assign user_wr_ready = w_user_ready;
  assign wr_data_out   = r_data;
  assign wr_data_strb  = r_strb;
  assign wr_data_valid = r_valid;
  assign wr_data_last  = r_last;
  assign wr_req_en     = (r_state == S_REQ);
  assign wr_addr_out   = w_addr_cur;
  assign wr_burst_len  = r_len;

endmodule
